// File: rtl/pblaze_timer_port.sv
// Interval timer and interrupt source on the PacoBlaze I/O port bus.
// Four byte registers are decoded at BASE_ADDR..BASE_ADDR+3.
// A prescaler divides clk, and COUNT counts down on each prescaler tick.
// On expiry the timer raises a level interrupt, which interrupt_ack clears.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   port_id             CPU port address
//   write_strobe        CPU write qualifier (one clk wide)
//   read_strobe         CPU read qualifier (reads have no side effects)
//   out_port            CPU write data
//   in_port             registered read data, 1 clk after port_id
//   interrupt           registered interrupt request (mirrors PEND)
//   interrupt_ack       CPU interrupt acknowledge (one clk pulse)
module pblaze_timer_port #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESC  = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // ctrl = {IE, AUTO, EN}
  logic [CW-1:0] ctrl, ctrl_n;
  logic [DW-1:0] prescale, prescale_n;
  logic [DW-1:0] reload, reload_n;
  logic [DW-1:0] count, count_n;
  logic [DW-1:0] pcnt, pcnt_n;
  logic          exp_flag, exp_n;
  logic          pend, pend_n;
  logic [DW-1:0] rdata_c;

  logic       sel;
  logic [1:0] off;
  logic       wr_ctrl, wr_presc, wr_reload, wr_status;
  logic       run, tick, expire, clr_stat;

  // Reads are side-effect free, so the read qualifier is not needed.
  logic unused_rd;
  assign unused_rd = read_strobe;

  // Address decode and per-register write enables.
  assign sel       = (port_id[7:2] == BASE_ADDR[7:2]);
  assign off       = port_id[1:0];
  assign wr_ctrl   = write_strobe && sel && (off == OFF_CTRL);
  assign wr_presc  = write_strobe && sel && (off == OFF_PRESC);
  assign wr_reload = write_strobe && sel && (off == OFF_COUNT);
  assign wr_status = write_strobe && sel && (off == OFF_STATUS);
  assign clr_stat  = wr_status && out_port[0];

  // A CTRL or RELOAD write restarts the prescaler, so no tick occurs that cycle.
  assign run    = ctrl[0] && !wr_ctrl && !wr_reload;
  assign tick   = run && (pcnt == '0);
  assign expire = tick && (count == '0);

  // Next-state logic for all timer registers.
  always_comb begin
    ctrl_n     = ctrl;
    prescale_n = prescale;
    reload_n   = reload;
    count_n    = count;
    pcnt_n     = pcnt;
    exp_n      = exp_flag;
    pend_n     = pend;

    // One-shot stop; a CTRL write below takes precedence.
    if (expire && !ctrl[1]) ctrl_n[0] = 1'b0;
    if (wr_ctrl) ctrl_n = out_port[CW-1:0];

    if (wr_presc) prescale_n = out_port;

    if (wr_ctrl || wr_reload) begin
      pcnt_n = prescale;
    end else if (run) begin
      pcnt_n = (pcnt == '0) ? prescale : pcnt - DW'(1);
    end

    if (wr_reload) begin
      reload_n = out_port;
      count_n  = out_port;
    end else if (tick) begin
      if (count != '0)  count_n = count - DW'(1);
      else if (ctrl[1]) count_n = reload;
      else              count_n = '0;
    end

    // Set on expiry wins over any clear in the same cycle.
    if (clr_stat) exp_n = 1'b0;
    if (expire)   exp_n = 1'b1;

    if (clr_stat || interrupt_ack) pend_n = 1'b0;
    if (expire && ctrl[2])         pend_n = 1'b1;
  end

  // Read mux; COUNT is read back at the RELOAD offset.
  always_comb begin
    rdata_c = '0;
    if (sel) begin
      unique case (off)
        OFF_CTRL:   rdata_c = {(DW-CW)'(0), ctrl};
        OFF_PRESC:  rdata_c = prescale;
        OFF_COUNT:  rdata_c = count;
        OFF_STATUS: rdata_c = {(DW-2)'(0), pend, exp_flag};
        default:    rdata_c = '0;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= '0;
      prescale  <= '0;
      reload    <= '0;
      count     <= '0;
      pcnt      <= '0;
      exp_flag  <= 1'b0;
      pend      <= 1'b0;
      in_port   <= '0;
      interrupt <= 1'b0;
    end else begin
      ctrl      <= ctrl_n;
      prescale  <= prescale_n;
      reload    <= reload_n;
      count     <= count_n;
      pcnt      <= pcnt_n;
      exp_flag  <= exp_n;
      pend      <= pend_n;
      in_port   <= rdata_c;
      interrupt <= pend_n;
    end
  end

endmodule

// File: tb/tb_pblaze_timer_port.sv
// Scoreboard bench for pblaze_timer_port (BASE_ADDR = 8'h40).
// The driver queues expected in_port/interrupt values tagged with the cycle they are due.
// A negedge monitor pops each entry on its cycle and compares it against the DUT.
module tb_pblaze_timer_port;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  pblaze_timer_port #(.BASE_ADDR(8'h40)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  // cyc is the count of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          is_irq;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Queue an expectation, kept sorted by due cycle.
  function automatic void push(input int unsigned c, input bit is_irq,
                               input logic [7:0] v, input string name);
    exp_t e;
    e.cyc = c; e.is_irq = is_irq; e.val = v; e.name = name;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  exp_t       me;
  logic [7:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      me = sb.pop_front();
      checks++;
      act = me.is_irq ? {7'b0, interrupt} : in_port;
      if (me.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d was missed (now %0d)", me.name, me.cyc, cyc);
      end else if (act !== me.val) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %02h expected %02h", me.name, cyc, act, me.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single-cycle write; we returns the edge that samples it.
  task automatic wr(input logic [7:0] a, input logic [7:0] d, output int unsigned we);
    port_id = a; out_port = d; write_strobe = 1'b1;
    we = cyc + 1;
    tick(1);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string name);
    port_id = a; read_strobe = 1'b1;
    push(cyc + 1, 1'b0, e, name);
    tick(1);
    read_strobe = 1'b0;
  endtask

  task automatic irq_at(input int unsigned c, input logic v, input string name);
    push(c, 1'b1, {7'b0, v}, name);
  endtask

  int unsigned w, s;

  initial begin
    reset = 1'b1; port_id = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = '0; interrupt_ack = 1'b0;
    tick(3);
    push(cyc + 1, 1'b0, 8'h00, "reset_in_port");
    irq_at(cyc + 1, 1'b0, "reset_irq");
    tick(1);
    reset = 1'b0;

    // Reset values of all four offsets.
    rd(8'h40, 8'h00, "rst_ctrl");
    rd(8'h41, 8'h00, "rst_presc");
    rd(8'h42, 8'h00, "rst_count");
    rd(8'h43, 8'h00, "rst_status");

    // Auto-reload: period (2+1)*(3+1) = 12 clks.
    wr(8'h41, 8'h03, w);
    wr(8'h42, 8'h02, w);
    wr(8'h40, 8'h07, w);
    irq_at(w + 11, 1'b0, "auto_irq_early");
    irq_at(w + 12, 1'b1, "auto_irq_rise");
    tick(12);
    rd(8'h43, 8'h03, "auto_status_pend");
    interrupt_ack = 1'b1;
    irq_at(cyc + 1, 1'b0, "ack_irq_fall");
    tick(1);
    interrupt_ack = 1'b0;
    rd(8'h43, 8'h01, "ack_status_exp_only");
    irq_at(w + 23, 1'b0, "auto_irq2_early");
    irq_at(w + 24, 1'b1, "auto_irq2_rise");
    tick(10);
    rd(8'h42, 8'h02, "auto_count_reloaded");
    wr(8'h40, 8'h00, s);
    wr(8'h43, 8'h01, s);
    rd(8'h43, 8'h00, "auto_status_cleared");
    irq_at(cyc, 1'b0, "auto_irq_cleared");
    tick(1);

    // One-shot: 6 clks, EN self-clears.
    wr(8'h41, 8'h00, w);
    wr(8'h42, 8'h05, w);
    wr(8'h40, 8'h05, w);
    irq_at(w + 5, 1'b0, "oneshot_irq_early");
    irq_at(w + 6, 1'b1, "oneshot_irq_rise");
    tick(6);
    rd(8'h40, 8'h04, "oneshot_ctrl_en_clear");
    rd(8'h42, 8'h00, "oneshot_count_zero");
    interrupt_ack = 1'b1;
    tick(1);
    interrupt_ack = 1'b0;
    tick(100);
    irq_at(cyc + 1, 1'b0, "oneshot_no_reexpiry");
    rd(8'h42, 8'h00, "oneshot_count_hold");
    rd(8'h43, 8'h01, "oneshot_status_exp");
    wr(8'h43, 8'h01, s);
    rd(8'h43, 8'h00, "oneshot_status_cleared");

    // IE=0: EXP sets every clk, interrupt never rises.
    wr(8'h42, 8'h00, w);
    wr(8'h40, 8'h03, w);
    tick(1);
    rd(8'h43, 8'h01, "noie_exp_set");
    irq_at(cyc, 1'b0, "noie_irq_low");
    wr(8'h43, 8'h01, s);
    tick(1);
    rd(8'h43, 8'h01, "noie_exp_resets");
    irq_at(cyc, 1'b0, "noie_irq_still_low");
    wr(8'h40, 8'h00, s);
    wr(8'h43, 8'h00, s);
    rd(8'h43, 8'h01, "status_write0_noop");
    wr(8'h43, 8'h01, s);
    rd(8'h43, 8'h00, "noie_status_cleared");

    // Collision: expiry every clk, so ack and STATUS clear both lose.
    wr(8'h40, 8'h07, w);
    irq_at(w + 1, 1'b1, "coll_irq_rise");
    tick(1);
    interrupt_ack = 1'b1;
    irq_at(cyc + 1, 1'b1, "coll_ack_irq_held");
    irq_at(cyc + 2, 1'b1, "coll_ack_irq_after");
    tick(1);
    interrupt_ack = 1'b0;
    irq_at(cyc + 1, 1'b1, "coll_stat_irq_held");
    wr(8'h43, 8'h01, s);
    rd(8'h43, 8'h03, "coll_status");
    wr(8'h40, 8'h00, s);
    irq_at(cyc + 1, 1'b0, "coll_final_clear");
    wr(8'h43, 8'h01, s);
    rd(8'h43, 8'h00, "coll_status_cleared");

    // Address decode around BASE_ADDR = 8'h40.
    push(cyc + 1, 1'b0, 8'h00, "decode_unsel_read");
    wr(8'h44, 8'hff, s);
    wr(8'h00, 8'hff, s);
    rd(8'h40, 8'h00, "decode_ctrl_untouched");
    wr(8'h41, 8'h09, s);
    rd(8'h41, 8'h09, "decode_presc_rw");

    // Reset mid-count with an interrupt pending.
    wr(8'h41, 8'h00, s);
    wr(8'h42, 8'h03, s);
    wr(8'h40, 8'h07, w);
    irq_at(w + 4, 1'b1, "midrst_irq_before");
    tick(6);
    reset = 1'b1;
    irq_at(cyc + 1, 1'b0, "midrst_irq_cleared");
    push(cyc + 1, 1'b0, 8'h00, "midrst_in_port");
    tick(1);
    reset = 1'b0;
    rd(8'h40, 8'h00, "midrst_ctrl");
    rd(8'h41, 8'h00, "midrst_presc");
    rd(8'h42, 8'h00, "midrst_count");
    rd(8'h43, 8'h00, "midrst_status");
    irq_at(cyc + 20, 1'b0, "midrst_no_irq");
    tick(21);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
